// File: rtl/alu_operand_issue_if.sv
// Shared types and the issue-stage port bundle:
// register-read side in, ALU operand side out.
package alu_operand_issue_pkg;

    localparam int unsigned ALU_XLEN = 32;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned RD_W     = 5;

    typedef enum logic [1:0] {
        LOGIC_ADD = 2'd0,
        LOGIC_XOR = 2'd1,
        LOGIC_OR  = 2'd2,
        LOGIC_AND = 2'd3
    } alu_logic_op_t;

    typedef enum logic [1:0] {
        RS1_ZERO = 2'd0,
        RS1_PC   = 2'd1,
        RS1_RF   = 2'd2
    } alu_rs1_op_t;

    typedef enum logic [1:0] {
        RS2_LUI_AUIPC = 2'd0,
        RS2_JAL_JALR  = 2'd1,
        RS2_ARITH_IMM = 2'd2,
        RS2_RF        = 2'd3
    } alu_rs2_op_t;

    typedef struct packed {
        logic [ALU_XLEN:0]   in1;
        logic [ALU_XLEN:0]   in2;
        logic [ALU_XLEN-1:0] shifter_in;
        logic [SHAMT_W-1:0]  shift_amount;
        alu_logic_op_t       logic_op;
        logic                subtract;
        logic                arith;
        logic                lshift;
        logic                shifter_path;
        logic                slt_path;
    } alu_inputs_t;

    typedef struct packed {
        alu_inputs_t     alu;
        logic [RD_W-1:0] rd;
        logic            illegal;
    } issue_entry_t;

endpackage

interface alu_operand_issue_if;
    import alu_operand_issue_pkg::*;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instr;
    logic [ALU_XLEN-1:0] pc;
    logic [ALU_XLEN-1:0] rs1_data;
    logic [ALU_XLEN-1:0] rs2_data;
    logic                out_valid;
    logic                out_ready;
    alu_inputs_t         alu_in;
    logic [RD_W-1:0]     rd;
    logic                illegal;

    modport slave (
        input  flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_in, rd, illegal
    );

    modport master (
        output flush, in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_in, rd, illegal
    );

endinterface

// File: rtl/alu_operand_issue.sv
// RV32I integer issue stage: decodes one instruction per cycle into the ALU
// operand bundle and hands it on through a two-entry skid buffer.
module alu_operand_issue
    import alu_operand_issue_pkg::*;
#(
    parameter int unsigned XLEN  = ALU_XLEN,
    parameter int unsigned DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_operand_issue_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] upper_imm;
    logic [XLEN-1:0] arith_imm;

    logic            legal;
    logic            is_arith;
    alu_rs1_op_t     rs1_sel;
    alu_rs2_op_t     rs2_sel;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            signed_pad;
    issue_entry_t    dec;

    skid_state_t     state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    issue_entry_t    out_q, out_d;
    issue_entry_t    skid_q, skid_d;
    logic            accept;
    logic            consume;

    assign opcode    = bus.instr[6:0];
    assign funct3    = bus.instr[14:12];
    assign funct7_5  = bus.instr[30];
    assign upper_imm = XLEN'({bus.instr[31:12], 12'b0});
    assign arith_imm = {{(XLEN-12){bus.instr[31]}}, bus.instr[31:20]};

    // Opcode -> operand source selection
    always_comb begin
        legal    = 1'b1;
        is_arith = 1'b0;
        rs1_sel  = RS1_RF;
        rs2_sel  = RS2_RF;
        case (opcode)
            OPC_LUI: begin
                rs1_sel = RS1_ZERO;
                rs2_sel = RS2_LUI_AUIPC;
            end
            OPC_AUIPC: begin
                rs1_sel = RS1_PC;
                rs2_sel = RS2_LUI_AUIPC;
            end
            OPC_JAL, OPC_JALR: begin
                rs1_sel = RS1_PC;
                rs2_sel = RS2_JAL_JALR;
            end
            OPC_OP_IMM: begin
                is_arith = 1'b1;
                rs2_sel  = RS2_ARITH_IMM;
            end
            OPC_OP: begin
                is_arith = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (rs1_sel)
            RS1_ZERO: op1 = '0;
            RS1_PC:   op1 = bus.pc;
            default:  op1 = bus.rs1_data;
        endcase
        case (rs2_sel)
            RS2_LUI_AUIPC: op2 = upper_imm;
            RS2_JAL_JALR:  op2 = XLEN'(4);
            RS2_ARITH_IMM: op2 = arith_imm;
            default:       op2 = bus.rs2_data;
        endcase
    end

    // funct3 flags and bundle assembly; only signed compares get a sign pad
    always_comb begin
        dec        = '0;
        signed_pad = 1'b0;
        dec.rd     = bus.instr[11:7];
        if (is_arith) begin
            case (funct3)
                3'b000: dec.alu.subtract = (opcode == OPC_OP) & funct7_5;
                3'b001: begin
                    dec.alu.shifter_path = 1'b1;
                    dec.alu.lshift       = 1'b1;
                end
                3'b010: begin
                    dec.alu.slt_path = 1'b1;
                    dec.alu.subtract = 1'b1;
                    signed_pad       = 1'b1;
                end
                3'b011: begin
                    dec.alu.slt_path = 1'b1;
                    dec.alu.subtract = 1'b1;
                end
                3'b100: dec.alu.logic_op = LOGIC_XOR;
                3'b101: begin
                    dec.alu.shifter_path = 1'b1;
                    dec.alu.arith        = funct7_5;
                end
                3'b110: dec.alu.logic_op = LOGIC_OR;
                default: dec.alu.logic_op = LOGIC_AND;
            endcase
        end
        dec.alu.in1          = {signed_pad & op1[XLEN-1], op1};
        dec.alu.in2          = {signed_pad & op2[XLEN-1], op2};
        dec.alu.shifter_in   = bus.rs1_data;
        dec.alu.shift_amount = op2[SHAMT_W-1:0];
        if (!legal) begin
            dec.alu     = '0;
            dec.illegal = 1'b1;
        end
    end

    assign accept  = bus.in_valid & in_ready_q;
    assign consume = out_valid_q & bus.out_ready;

    // Skid next-state: output register first, skid entry only when stalled
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    out_d   = dec;
                end
            end
            ONE: begin
                if (accept && !consume) begin
                    state_d = TWO;
                    skid_d  = dec;
                end else if (accept && consume) begin
                    out_d = dec;
                end else if (consume) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (consume) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush) begin
            state_d = EMPTY;
            out_d   = out_q;
            skid_d  = skid_q;
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (32'(state_d) < DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.alu_in    = out_q.alu;
    assign bus.rd        = out_q.rd;
    assign bus.illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Directed and random checks of alu_operand_issue against a queue-based
// reference model of the decode rules and two-deep FIFO behaviour.
module tb_alu_operand_issue;
    import alu_operand_issue_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    alu_operand_issue_if bif ();

    alu_operand_issue #(.XLEN(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    issue_entry_t q[$];
    bit           model_rdy;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Decode rules written directly from the instruction semantics
    function automatic issue_entry_t ref_model(input logic [31:0] ins, input logic [31:0] pc_v,
                                               input logic [31:0] a, input logic [31:0] b);
        issue_entry_t e;
        logic [31:0]  x;
        logic [31:0]  y;
        logic         sgn;
        logic [6:0]   opc;
        e   = '0;
        x   = '0;
        y   = '0;
        sgn = 1'b0;
        opc = ins[6:0];
        e.rd = ins[11:7];
        case (opc)
            7'h37: begin x = 32'd0; y = {ins[31:12], 12'h000}; end
            7'h17: begin x = pc_v;  y = {ins[31:12], 12'h000}; end
            7'h6F, 7'h67: begin x = pc_v; y = 32'd4; end
            7'h13, 7'h33: begin
                x = a;
                y = (opc == 7'h33) ? b : {{20{ins[31]}}, ins[31:20]};
                case (ins[14:12])
                    3'd0: e.alu.subtract = (opc == 7'h33) && ins[30];
                    3'd1: begin e.alu.shifter_path = 1'b1; e.alu.lshift = 1'b1; end
                    3'd2: begin e.alu.slt_path = 1'b1; e.alu.subtract = 1'b1; sgn = 1'b1; end
                    3'd3: begin e.alu.slt_path = 1'b1; e.alu.subtract = 1'b1; end
                    3'd4: e.alu.logic_op = LOGIC_XOR;
                    3'd5: begin e.alu.shifter_path = 1'b1; e.alu.arith = ins[30]; end
                    3'd6: e.alu.logic_op = LOGIC_OR;
                    default: e.alu.logic_op = LOGIC_AND;
                endcase
            end
            default: begin
                e.illegal = 1'b1;
                return e;
            end
        endcase
        e.alu.in1          = {sgn & x[31], x};
        e.alu.in2          = {sgn & y[31], y};
        e.alu.shifter_in   = a;
        e.alu.shift_amount = y[4:0];
        return e;
    endfunction

    // One clock: drive at negedge, advance model at posedge, compare at next negedge
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc_v,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic ordy, input logic fl, input logic rstn);
        bit acc;
        bit cons;
        bif.in_valid  = v;
        bif.instr     = ins;
        bif.pc        = pc_v;
        bif.rs1_data  = a;
        bif.rs2_data  = b;
        bif.out_ready = ordy;
        bif.flush     = fl;
        rst_n         = rstn;
        acc  = v && model_rdy;
        cons = (q.size() != 0) && ordy;
        @(posedge clk);
        if (!rstn) begin
            q.delete();
            model_rdy = 1'b0;
        end else if (fl) begin
            q.delete();
            model_rdy = 1'b1;
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(ref_model(ins, pc_v, a, b));
            model_rdy = (q.size() < 2);
        end
        @(negedge clk);
        check("out_valid", 128'(bif.out_valid), 128'(q.size() != 0));
        check("in_ready", 128'(bif.in_ready), 128'(model_rdy));
        if (q.size() != 0) begin
            check("alu_in", 128'({bif.alu_in}), 128'({q[0].alu}));
            check("rd", 128'(bif.rd), 128'(q[0].rd));
            check("illegal", 128'(bif.illegal), 128'(q[0].illegal));
        end else if (!rstn) begin
            check("rst_alu_in", 128'({bif.alu_in}), 128'(0));
            check("rst_rd", 128'(bif.rd), 128'(0));
            check("rst_illegal", 128'(bif.illegal), 128'(0));
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opc;
        ins = $urandom;
        case ($urandom_range(0, 6))
            0: opc = 7'h37;
            1: opc = 7'h17;
            2: opc = 7'h6F;
            3: opc = 7'h67;
            4: opc = 7'h13;
            5: opc = 7'h33;
            default: opc = 7'h7F;
        endcase
        ins[6:0] = opc;
        return ins;
    endfunction

    localparam logic [31:0] I_ADDI = 32'hFFF08093;
    localparam logic [31:0] I_SLT  = 32'h0020A1B3;
    localparam logic [31:0] I_SLTU = 32'h0020B1B3;
    localparam logic [31:0] I_SRA  = 32'h4020D233;
    localparam logic [31:0] I_JAL  = 32'h000000EF;
    localparam logic [31:0] I_LUI  = 32'h123452B7;
    localparam logic [31:0] I_ADD6 = 32'h00208333;
    localparam logic [31:0] I_ADD7 = 32'h002083B3;
    localparam logic [31:0] I_ADD8 = 32'h00208433;

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        model_rdy     = 1'b0;
        rst_n         = 1'b0;
        bif.flush     = 1'b0;
        bif.in_valid  = 1'b0;
        bif.instr     = '0;
        bif.pc        = '0;
        bif.rs1_data  = '0;
        bif.rs2_data  = '0;
        bif.out_ready = 1'b0;
        @(negedge clk);

        // Reset then release
        step(1'b1, I_ADDI, 32'h0, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
        check("release_in_ready", 128'(bif.in_ready), 128'(1));

        // ADDI x1,x1,-1
        step(1'b1, I_ADDI, 32'h0, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1);
        check("addi_valid", 128'(bif.out_valid), 128'(1));
        check("addi_in1", 128'(bif.alu_in.in1), 128'(33'h0_00000005));
        check("addi_in2", 128'(bif.alu_in.in2), 128'(33'h0_FFFFFFFF));
        check("addi_logic_op", 128'(bif.alu_in.logic_op), 128'(LOGIC_ADD));
        check("addi_subtract", 128'(bif.alu_in.subtract), 128'(0));
        check("addi_rd", 128'(bif.rd), 128'(1));

        // SLT vs SLTU, back to back
        step(1'b1, I_SLT, 32'h0, 32'h80000000, 32'd1, 1'b1, 1'b0, 1'b1);
        check("slt_in1", 128'(bif.alu_in.in1), 128'(33'h1_80000000));
        check("slt_in2", 128'(bif.alu_in.in2), 128'(33'h0_00000001));
        check("slt_path", 128'(bif.alu_in.slt_path), 128'(1));
        check("slt_subtract", 128'(bif.alu_in.subtract), 128'(1));
        step(1'b1, I_SLTU, 32'h0, 32'h80000000, 32'd1, 1'b1, 1'b0, 1'b1);
        check("sltu_in1", 128'(bif.alu_in.in1), 128'(33'h0_80000000));

        // SRA, JAL, LUI
        step(1'b1, I_SRA, 32'h0, 32'hF0000000, 32'd36, 1'b1, 1'b0, 1'b1);
        check("sra_arith", 128'(bif.alu_in.arith), 128'(1));
        check("sra_shamt", 128'(bif.alu_in.shift_amount), 128'(4));
        step(1'b1, I_JAL, 32'h100, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("jal_in1", 128'(bif.alu_in.in1), 128'(33'h100));
        check("jal_in2", 128'(bif.alu_in.in2), 128'(33'h4));
        step(1'b1, I_LUI, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("lui_in1", 128'(bif.alu_in.in1), 128'(0));
        check("lui_in2", 128'(bif.alu_in.in2), 128'(33'h0_12345000));

        // Backpressure: three presented, two accepted, drained in order
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        step(1'b1, I_ADD6, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, I_ADD7, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        check("bp_in_ready", 128'(bif.in_ready), 128'(0));
        step(1'b1, I_ADD8, 32'h0, 32'd5, 32'd6, 1'b0, 1'b0, 1'b1);
        check("bp_hold_rd", 128'(bif.rd), 128'(6));
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("bp_second_rd", 128'(bif.rd), 128'(7));
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("bp_drained", 128'(bif.out_valid), 128'(0));

        // Flush while full drops everything, including the presented instruction
        step(1'b1, I_ADD6, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, I_ADD7, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        step(1'b1, I_ADD8, 32'h0, 32'd5, 32'd6, 1'b0, 1'b1, 1'b1);
        check("flush_valid", 128'(bif.out_valid), 128'(0));
        check("flush_in_ready", 128'(bif.in_ready), 128'(1));
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        check("flush_dropped", 128'(bif.out_valid), 128'(0));

        // Mid-stream reset
        step(1'b1, I_ADD6, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b1);
        step(1'b1, I_ADD7, 32'h0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
        check("mid_rst_valid", 128'(bif.out_valid), 128'(0));
        check("mid_rst_in_ready", 128'(bif.in_ready), 128'(0));
        check("mid_rst_rd", 128'(bif.rd), 128'(0));
        step(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Illegal opcode
        step(1'b1, 32'h0000007F, 32'h40, 32'h1234, 32'h5678, 1'b1, 1'b0, 1'b1);
        check("illegal_flag", 128'(bif.illegal), 128'(1));
        check("illegal_alu_in", 128'({bif.alu_in}), 128'(0));

        // Random traffic with backpressure, occasional flush and reset
        for (int i = 0; i < 600; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, a, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 99) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_issue.md
# alu_operand_issue

Issue stage that produces the ALU's `alu_inputs_t` operand bundle. It accepts one RV32I integer instruction per cycle from register read, with its PC and register-file operands. It decodes the opcode and funct fields, selects the rs1 and rs2 sources (`alu_rs1_op_t` / `alu_rs2_op_t`), builds the sign-padded operand bundle, and presents it to the ALU through a registered valid/ready interface. A two-entry skid buffer gives a fully registered `in_ready` and full throughput.

## Interface
- `XLEN`, 32: datapath width. `in1`/`in2` are `XLEN+1` bits wide.
- `DEPTH`, 2: skid capacity, output register plus one skid entry. Fixed; no other value is supported.

- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `flush` in 1: drops every held entry.
- `in_valid` in 1: upstream has an instruction.
- `in_ready` out 1: this block can accept an instruction. Registered.
- `instr` in 32: instruction word.
- `pc` in XLEN: PC of `instr`.
- `rs1_data` in XLEN: register-file value for rs1.
- `rs2_data` in XLEN: register-file value for rs2.
- `out_valid` out 1: the bundle on the output is valid.
- `out_ready` in 1: the ALU accepts the bundle.
- `alu_in` out `$bits(alu_inputs_t)`: operand bundle, type `alu_inputs_t`.
- `rd` out 5: destination register, `instr[11:7]`.
- `illegal` out 1: the opcode is not one of the 6 supported opcodes.

## Operation
- **Rs1 source:** ZERO for LUI, PC for AUIPC/JAL/JALR, RF for OP-IMM/OP.
- **Rs2 source:**
  - LUI_AUIPC: `{instr[31:12],12'b0}`.
  - JAL_JALR: constant 4.
  - ARITH_IMM: sign-extended `instr[31:20]`.
  - RF: `rs2_data`.
- **Padding:** `in1`/`in2` = `{pad, operand}`.
  - pad = operand MSB for SLT/SLTI.
  - pad = 0 for every other operation, including SLTU/SLTIU.
- **Fixed fields:** `shifter_in` = `rs1_data`; `shift_amount` = `in2[4:0]`.
- **funct3 decode (OP and OP-IMM):**
  - 000: ADD. `subtract` is set only for OP with `funct7[5]`.
  - 001: SLL. `shifter_path`=1, `lshift`=1.
  - 010 / 011: SLT / SLTU. `slt_path`=1, `subtract`=1.
  - 100: XOR, `logic_op`=XOR.
  - 101: SRL / SRA. `shifter_path`=1, `arith`=`funct7[5]`.
  - 110: OR, `logic_op`=OR.
  - 111: AND, `logic_op`=AND.
- **`logic_op` default:** ADD for add/sub, SLT and shifts. LUI/AUIPC/JAL/JALR use ADD with every flag 0.
- **Illegal opcode:** `illegal`=1 and all `alu_in` fields = 0. The entry still flows through the handshake normally.
- **Skid FSM (EMPTY, ONE, TWO):**
  - EMPTY: accept → ONE.
  - ONE:
    - accept without consume → TWO (new entry goes to skid).
    - accept with consume → ONE (output reg reloaded).
    - consume without accept → EMPTY.
  - TWO: consume → ONE; skid moves to output reg.
  - `in_ready` = (state != TWO), registered from next state.
- **Handshake terms:** accept = `in_valid & in_ready`; consume = `out_valid & out_ready`.
- **Flush:** next state EMPTY and `out_valid`=0. It overrides an accept or consume in the same cycle, so an instruction presented that cycle is dropped.
- **Reset:**
  - `out_valid`=0, `alu_in`=0, `rd`=0, `illegal`=0, state EMPTY.
  - `in_ready`=0 while `rst_n`=0 and 1 in the first cycle after release.

## Timing
- Latency: an accept at edge N gives `out_valid`=1 after edge N; the ALU can consume at edge N+1.
- Throughput: 1 per cycle while `out_ready`=1.
- Stability: `alu_in`, `rd` and `illegal` hold steady while `out_valid` & !`out_ready`.
- No combinational path from any input to any output.
- Ordering is strictly FIFO.

## Test plan
- **ADDI:** `instr`=0xFFF08093 (addi x1,x1,-1), `rs1_data`=5.
  - `in1`=0x0_00000005, `in2`=0x0_FFFFFFFF.
  - `logic_op`=ADD, `subtract`=0, `rd`=1, one cycle later.
- **SLT vs SLTU:** `rs1_data`=0x80000000, `rs2_data`=1.
  - SLT: `in1`=0x1_80000000, `in2`=0x0_00000001, `slt_path`=1, `subtract`=1.
  - SLTU: `in1`=0x0_80000000.
- **SRA / JAL / LUI:**
  - SRA (funct7=0x20, rs2=36): `arith`=1, `shift_amount`=4.
  - JAL at `pc`=0x100: `in1`=0x100, `in2`=4.
  - LUI 0x12345: `in1`=0, `in2`=0x12345000.
- **Backpressure:** `out_ready`=0 with 3 back-to-back `in_valid`.
  - Two instructions accepted, `in_ready`=0 after the second.
  - Release `out_ready`: outputs arrive in order, one per cycle, with no loss or duplicates.
- **Flush:** in state TWO, assert `flush` with `in_valid`=1.
  - Next cycle `out_valid`=0, `in_ready`=1, and the presented instruction is dropped.
- **Reset / illegal:**
  - Mid-stream `rst_n`=0: all outputs 0 and `in_ready`=0.
  - Opcode 0x7F: `illegal`=1 and `alu_in`=0.
